mips_muldiv: RTL

//  Iterative multiply/divide unit and HI/LO register pair for the MIPS core's execute stage.

---
 rtl/mips_muldiv_pkg.sv | 25 ++
 rtl/mips_muldiv_cond_negate.sv | 12 +
 rtl/mips_muldiv.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states, helpers.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_t;

  localparam int unsigned MD_CNT_W = 5;

  function automatic logic md_op_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_cond_negate.sv
// Two's-complement conditional negate: out = neg ? -in : in. Purely combinational.
module cond_negate #(
  parameter int width = 32
) (
  input  logic [width-1:0] in_i,
  input  logic             neg_i,
  output logic [width-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + {{(width-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit: shift-add MUL / restoring DIV on magnitudes, sign fix in FIX.
// Latency 33 busy cycles (MUL with fast_mul=1: 1); start while busy is dropped, stall holds the core.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int width    = 32,
  parameter bit fast_mul = 1'b0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  md_op_t           op,
  input  logic [width-1:0] rs_data,
  input  logic [width-1:0] rt_data,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo,
  output logic             div_zero
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(width - 1);

  md_state_t              state_q, state_d;
  logic [MD_CNT_W-1:0]    cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [width-1:0]       b_q, b_d;
  logic [2*width-1:0]     p_q, p_d;
  logic [width-1:0]       rem_q, rem_d;
  logic [width-1:0]       hi_q, hi_d;
  logic [width-1:0]       lo_q, lo_d;
  logic                   dz_q, dz_d;

  logic                   op_sgn;
  logic [width-1:0]       abs_a, abs_b;
  logic [width:0]         mul_sum;
  logic [width:0]         div_shift;
  logic                   div_ge;
  logic [width-1:0]       div_sub;
  logic [2*width-1:0]     fast_prod;
  logic [2*width-1:0]     prod_fix;
  logic [width-1:0]       quo_fix, rem_fix;

  assign op_sgn = md_op_signed(op);

  cond_negate #(.width(width)) u_abs_a (
    .in_i  (rs_data),
    .neg_i (op_sgn & rs_data[width-1]),
    .out_o (abs_a)
  );

  cond_negate #(.width(width)) u_abs_b (
    .in_i  (rt_data),
    .neg_i (op_sgn & rt_data[width-1]),
    .out_o (abs_b)
  );

  cond_negate #(.width(2*width)) u_fix_prod (
    .in_i  (p_q),
    .neg_i (neg_quo_q),
    .out_o (prod_fix)
  );

  cond_negate #(.width(width)) u_fix_quo (
    .in_i  (p_q[width-1:0]),
    .neg_i (neg_quo_q),
    .out_o (quo_fix)
  );

  cond_negate #(.width(width)) u_fix_rem (
    .in_i  (rem_q),
    .neg_i (neg_rem_q),
    .out_o (rem_fix)
  );

  // Multiply: upper half accumulates, whole product shifts right one bit per iteration.
  assign mul_sum   = {1'b0, p_q[2*width-1:width]} + (p_q[0] ? {1'b0, b_q} : {(width+1){1'b0}});
  // Divide: dividend bits enter from the top of p_q[width-1:0], quotient bits fill in at the bottom.
  assign div_shift = {rem_q, p_q[width-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_sub   = div_shift[width-1:0] - b_q;
  assign fast_prod = {{width{1'b0}}, abs_a} * {{width{1'b0}}, abs_b};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    b_d       = b_q;
    p_d       = p_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (op)
            MD_MTHI: hi_d = rs_data;
            MD_MTLO: lo_d = rs_data;
            MD_MULT, MD_MULTU: begin
              b_d       = abs_b;
              is_div_d  = 1'b0;
              neg_quo_d = op_sgn & (rs_data[width-1] ^ rt_data[width-1]);
              neg_rem_d = op_sgn & rs_data[width-1];
              cnt_d     = CNT_LAST;
              if (fast_mul) begin
                p_d     = fast_prod;
                state_d = MD_FIX;
              end else begin
                p_d     = {{width{1'b0}}, abs_a};
                state_d = MD_RUN;
              end
            end
            MD_DIV, MD_DIVU: begin
              if (rt_data == '0) begin
                hi_d = rs_data;
                lo_d = '1;
                dz_d = 1'b1;
              end else begin
                b_d       = abs_b;
                p_d       = {{width{1'b0}}, abs_a};
                rem_d     = '0;
                is_div_d  = 1'b1;
                neg_quo_d = op_sgn & (rs_data[width-1] ^ rt_data[width-1]);
                neg_rem_d = op_sgn & rs_data[width-1];
                cnt_d     = CNT_LAST;
                state_d   = MD_RUN;
              end
            end
            default: ;
          endcase
        end
      end

      MD_RUN: begin
        if (is_div_q) begin
          p_d   = {p_q[2*width-1:width], p_q[width-2:0], div_ge};
          rem_d = div_ge ? div_sub : div_shift[width-1:0];
        end else begin
          p_d = {mul_sum, p_q[width-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = MD_IDLE;
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= '0;
      p_q       <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      b_q       <= b_d;
      p_q       <= p_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign stall    = busy & (rd_req | start);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule
